// File: rtl/lcd_char_source.sv
// Two-button character selector for an LCD: synchronized, debounced up/down buttons step a printable ASCII code.
// Optional auto-repeat while a button is held is enabled by defining LCD_CHAR_AUTO_REPEAT_EN.
module lcd_char_source #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_n,
  input  logic       btn_dn_n,
  output logic [7:0] char_out,
  output logic       step_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [7:0] CHAR_RESET = 8'h41;
  localparam logic [7:0] CHAR_MIN   = 8'h20;
  localparam logic [7:0] CHAR_MAX   = 8'h7E;

  // Arming needs a stable window longer than the synchronizer's reset-released latency.
  if (DEBOUNCE_CYC < 3 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("lcd_char_source: DEBOUNCE_CYC must be >= 3 and repeat timings >= 1");
  end

  function automatic logic [7:0] char_next(input logic [7:0] c, input logic up);
    logic [7:0] n;
    if (up) n = (c >= CHAR_MAX) ? CHAR_MIN : c + 8'd1;
    else    n = (c <= CHAR_MIN) ? CHAR_MAX : c - 8'd1;
    return n;
  endfunction

`ifdef LCD_CHAR_AUTO_REPEAT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_REPEAT = 2'd2} state_t;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(RMAX + 1);
  logic [TW-1:0] timer_r, timer_nxt_s;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1} state_t;
`endif

  state_t state_r, state_nxt_s;
  logic   up_meta_r, up_sync_r, dn_meta_r, dn_sync_r;
  logic [1:0]         sync_s, db_n_r;
  logic [1:0][DW-1:0] db_cnt_r;
  logic [DW-1:0]      arm_cnt_r;
  logic armed_r, dir_r, dir_nxt_s, step_s, step_up_s;
  logic up_p_s, dn_p_s, hold_ok_s;

  assign sync_s    = {dn_sync_r, up_sync_r};
  assign up_p_s    = ~db_n_r[0];
  assign dn_p_s    = ~db_n_r[1];
  assign hold_ok_s = dir_r ? (up_p_s & ~dn_p_s) : (dn_p_s & ~up_p_s);

  // Two-flop synchronizers for both raw buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_meta_r <= 1'b1;
      up_sync_r <= 1'b1;
      dn_meta_r <= 1'b1;
      dn_sync_r <= 1'b1;
    end else begin
      up_meta_r <= btn_up_n;
      up_sync_r <= up_meta_r;
      dn_meta_r <= btn_dn_n;
      dn_sync_r <= dn_meta_r;
    end
  end

  // Per-button debounce; arming requires both buttons released so a press held through reset is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_n_r    <= 2'b11;
      db_cnt_r  <= '0;
      arm_cnt_r <= '0;
      armed_r   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_s[i] != db_n_r[i]) begin
          if (db_cnt_r[i] == DW'(DEBOUNCE_CYC - 1)) begin
            db_n_r[i]   <= sync_s[i];
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
          end
        end else begin
          db_cnt_r[i] <= '0;
        end
      end
      if (!armed_r) begin
        if (sync_s == 2'b11) begin
          if (arm_cnt_r == DW'(DEBOUNCE_CYC - 1)) armed_r <= 1'b1;
          arm_cnt_r <= arm_cnt_r + DW'(1);
        end else begin
          arm_cnt_r <= '0;
        end
      end
    end
  end

  // Control FSM next-state and step decision.
  always_comb begin
    state_nxt_s = state_r;
    dir_nxt_s   = dir_r;
    step_s      = 1'b0;
    step_up_s   = dir_r;
`ifdef LCD_CHAR_AUTO_REPEAT_EN
    timer_nxt_s = timer_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (armed_r && (up_p_s ^ dn_p_s)) begin
          step_s      = 1'b1;
          step_up_s   = up_p_s;
          dir_nxt_s   = up_p_s;
          state_nxt_s = S_HOLD;
`ifdef LCD_CHAR_AUTO_REPEAT_EN
          timer_nxt_s = '0;
`endif
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!hold_ok_s) begin
          state_nxt_s = S_IDLE;
        end else begin
`ifdef LCD_CHAR_AUTO_REPEAT_EN
          if (timer_r == TW'(REPEAT_DELAY - 1)) begin
            step_s      = 1'b1;
            timer_nxt_s = '0;
            state_nxt_s = S_REPEAT;
          end else begin
            timer_nxt_s = timer_r + TW'(1);
          end
`else
          state_nxt_s = S_HOLD;
`endif
        end
      end
`ifdef LCD_CHAR_AUTO_REPEAT_EN
      S_REPEAT: begin
        if (!hold_ok_s) begin
          state_nxt_s = S_IDLE;
        end else if (timer_r == TW'(REPEAT_RATE - 1)) begin
          step_s      = 1'b1;
          timer_nxt_s = '0;
        end else begin
          timer_nxt_s = timer_r + TW'(1);
        end
      end
`endif
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      dir_r      <= 1'b0;
      char_out   <= CHAR_RESET;
      step_pulse <= 1'b0;
`ifdef LCD_CHAR_AUTO_REPEAT_EN
      timer_r    <= '0;
`endif
    end else begin
      state_r    <= state_nxt_s;
      dir_r      <= dir_nxt_s;
      step_pulse <= step_s;
      if (step_s) char_out <= char_next(char_out, step_up_s);
`ifdef LCD_CHAR_AUTO_REPEAT_EN
      timer_r    <= timer_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_char_source.sv
// Randomized and directed bench for lcd_char_source against a press-timeline reference model.
module tb_lcd_char_source;

  localparam int DEB  = 4;
  localparam int DLY  = 20;
  localparam int RATE = 8;
`ifdef LCD_CHAR_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, btn_up_n, btn_dn_n;
  logic [7:0] char_out;
  logic       step_pulse;

  always #5 clk = ~clk;

  lcd_char_source #(.DEBOUNCE_CYC(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut (
    .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
    .char_out(char_out), .step_pulse(step_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: pipeline delays, stable-run debounce, and step times as offsets from the press.
  bit m_meta_up, m_sync_up, m_meta_dn, m_sync_dn, m_prs_up, m_prs_dn, m_armed, m_pulse;
  int m_run_up, m_run_dn, m_arm_run, m_held, m_elapsed, m_char;

  function automatic int wrap_step(input int c, input bit up);
    return up ? ((c - 32 + 1) % 95) + 32 : ((c - 32 + 94) % 95) + 32;
  endfunction

  task automatic model_reset();
    m_meta_up = 1'b1; m_sync_up = 1'b1; m_meta_dn = 1'b1; m_sync_dn = 1'b1;
    m_prs_up = 1'b0; m_prs_dn = 1'b0; m_armed = 1'b0; m_pulse = 1'b0;
    m_run_up = 0; m_run_dn = 0; m_arm_run = 0; m_held = 0; m_elapsed = 0;
    m_char = 32'h41;
  endtask

  task automatic model_edge(input bit up_n, input bit dn_n);
    bit pu, pd, step, dir, still;
    pu = m_prs_up; pd = m_prs_dn; step = 1'b0; dir = 1'b0;
    if (m_held == 0) begin
      if (m_armed && (pu != pd)) begin
        step = 1'b1; dir = pu; m_held = pu ? 1 : 2; m_elapsed = 0;
      end
    end else begin
      still = (m_held == 1) ? (pu && !pd) : (pd && !pu);
      if (still) begin
        m_elapsed++;
        if (AUTO && (m_elapsed == DLY || (m_elapsed > DLY && (m_elapsed - DLY) % RATE == 0))) begin
          step = 1'b1; dir = (m_held == 1);
        end
      end else begin
        m_held = 0;
      end
    end
    m_pulse = step;
    if (step) m_char = wrap_step(m_char, dir);
    if ((!m_sync_up) != m_prs_up) begin
      m_run_up++;
      if (m_run_up == DEB) begin m_prs_up = !m_sync_up; m_run_up = 0; end
    end else m_run_up = 0;
    if ((!m_sync_dn) != m_prs_dn) begin
      m_run_dn++;
      if (m_run_dn == DEB) begin m_prs_dn = !m_sync_dn; m_run_dn = 0; end
    end else m_run_dn = 0;
    if (!m_armed) begin
      if (m_sync_up && m_sync_dn) begin
        m_arm_run++;
        if (m_arm_run == DEB) m_armed = 1'b1;
      end else m_arm_run = 0;
    end
    m_sync_up = m_meta_up; m_meta_up = up_n;
    m_sync_dn = m_meta_dn; m_meta_dn = dn_n;
  endtask

  task automatic cycle(input bit up_n, input bit dn_n, input bit rst);
    @(negedge clk);
    btn_up_n = up_n; btn_dn_n = dn_n; rst_n = rst;
    if (!rst) begin
      #1;
      model_reset();
      check_eq("async_rst_char", char_out, 32'h41);
    end
    @(posedge clk);
    if (rst) model_edge(up_n, dn_n);
    else     model_reset();
    #1;
    if (step_pulse === 1'b1) pulses++;
    check_eq("char_out", char_out, m_char);
    check_eq("step_pulse", step_pulse, m_pulse);
  endtask

  task automatic hold(input bit up_n, input bit dn_n, input int n);
    repeat (n) cycle(up_n, dn_n, 1'b1);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    hold(1'b1, 1'b1, 10);
  endtask

  int p0;
  bit ru, rd;

  initial begin
    rst_n = 1'b0; btn_up_n = 1'b1; btn_dn_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check_eq("reset_char", char_out, 32'h41);
    check_eq("reset_pulse", step_pulse, 32'h0);

    hold(1'b1, 1'b1, 30);
    check_eq("idle_char", char_out, 32'h41);
    check_eq("idle_pulses", pulses, 32'h0);

    // Short press and glitches must be filtered out.
    hold(1'b0, 1'b1, 3); hold(1'b1, 1'b1, 6);
    hold(1'b0, 1'b1, 1); hold(1'b1, 1'b1, 1); hold(1'b0, 1'b1, 2); hold(1'b1, 1'b1, 1);
    hold(1'b0, 1'b1, 3); hold(1'b1, 1'b1, 10);
    check_eq("glitch_char", char_out, 32'h41);
    p0 = pulses;
    hold(1'b0, 1'b1, 10); hold(1'b1, 1'b1, 12);
    check_eq("press_char", char_out, 32'h42);
    check_eq("press_pulses", pulses - p0, 32'h1);

    // Wrap boundaries.
    do_reset();
    repeat (33) begin hold(1'b1, 1'b0, 10); hold(1'b1, 1'b1, 10); end
    check_eq("down_to_min", char_out, 32'h20);
    hold(1'b1, 1'b0, 10); hold(1'b1, 1'b1, 10);
    check_eq("wrap_down", char_out, 32'h7E);
    hold(1'b0, 1'b1, 10); hold(1'b1, 1'b1, 10);
    check_eq("wrap_up", char_out, 32'h20);

    // Long hold: auto-repeat or single step.
    do_reset();
    hold(1'b0, 1'b1, 60); hold(1'b1, 1'b1, 15);
    check_eq("long_hold", char_out, AUTO ? 32'h47 : 32'h42);

    // Both together, then second button during a hold.
    do_reset();
    hold(1'b0, 1'b0, 30); hold(1'b1, 1'b1, 12);
    check_eq("both_no_step", char_out, 32'h41);
    hold(1'b0, 1'b1, 12); hold(1'b0, 1'b0, 40); hold(1'b1, 1'b1, 12);
    check_eq("other_abort", char_out, 32'h42);

    // Reset mid-repeat with the button still held.
    do_reset();
    hold(1'b0, 1'b1, 40);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    p0 = pulses;
    hold(1'b0, 1'b1, 60);
    check_eq("rst_hold_char", char_out, 32'h41);
    check_eq("rst_hold_pulses", pulses - p0, 32'h0);
    hold(1'b1, 1'b1, 12); hold(1'b0, 1'b1, 10); hold(1'b1, 1'b1, 12);
    check_eq("rst_fresh_press", char_out, 32'h42);

    // Random segments checked cycle by cycle against the model.
    do_reset();
    repeat (40) begin
      ru = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      hold(ru, rd, $urandom_range(1, 45));
    end
    hold(1'b1, 1'b1, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_char_source.md
LCD_CHAR_SOURCE -- requirements
Module: lcd_char_source

Interface
REQ-001 The block SHALL run on one clock and reset asynchronously active-low via rst_n; no other clock or reset exists.
REQ-002 Parameter DEBOUNCE_CYC SHALL default to 1000000 and set the stable-input cycles required (20 ms at 50 MHz).
REQ-003 Parameter REPEAT_DELAY SHALL default to 25000000 and set the hold cycles before the first auto-repeat step (500 ms).
REQ-004 Parameter REPEAT_RATE SHALL default to 5000000 and set the cycles between auto-repeat steps (100 ms).
REQ-005 Port clk SHALL be input, 1 bit, the 50 MHz system clock.
REQ-006 Port rst_n SHALL be input, 1 bit, the asynchronous active-low reset.
REQ-007 Port btn_up_n SHALL be input, 1 bit, raw active-low button that increments the character.
REQ-008 Port btn_dn_n SHALL be input, 1 bit, raw active-low button that decrements the character.
REQ-009 Port char_out SHALL be output, 8 bits, the registered ASCII code that drives the LCD driver's input_data.
REQ-010 Port step_pulse SHALL be output, 1 bit, high for exactly one cycle each time char_out changes.

Function
REQ-011 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-012 Each synchronized button SHALL have its own debounce counter; the debounced level SHALL update only after the synchronized level differs from it for DEBOUNCE_CYC consecutive cycles, and the counter SHALL clear on any cycle where the two match.
REQ-013 The control FSM SHALL have the states S_IDLE, S_HOLD and S_REPEAT, plus one shared repeat timer.
REQ-014 In S_IDLE, when exactly one debounced button is pressed, the FSM SHALL step once in that button's direction, load the timer, and go to S_HOLD.
REQ-015 In S_HOLD, when the timer reaches REPEAT_DELAY-1, the FSM SHALL step once, reload the timer, and go to S_REPEAT.
REQ-016 In S_REPEAT, the FSM SHALL step once each time the timer reaches REPEAT_RATE-1, then reload the timer.
REQ-017 In S_HOLD or S_REPEAT, when the held button releases or the other button also presses, the FSM SHALL return to S_IDLE on the next cycle without stepping.
REQ-018 When both debounced buttons press in the same cycle while in S_IDLE, the FSM SHALL not step and SHALL stay in S_IDLE.
REQ-019 char_out SHALL update on the clock edge after the cycle in which the debounced press is first seen, and step_pulse SHALL be asserted in that same cycle.
REQ-020 char_out SHALL stay within printable ASCII 0x20..0x7E; an increment from 0x7E SHALL give 0x20, and a decrement from 0x20 SHALL give 0x7E.
REQ-021 char_out SHALL change only through a step and SHALL hold its value indefinitely otherwise.

Reset
REQ-022 Asserting rst_n low SHALL immediately force char_out=0x41, step_pulse=0, the FSM to S_IDLE, all counters and timers to 0, synchronizer flops to 1, and both debounced levels to released.
REQ-023 A reset asserted mid-hold SHALL require a fresh debounced press after release before the next step occurs.

Configuration
REQ-024 With macro LCD_CHAR_AUTO_REPEAT_EN defined, S_REPEAT and the REPEAT_DELAY/REPEAT_RATE timing SHALL be present as specified above.
REQ-025 Without LCD_CHAR_AUTO_REPEAT_EN, S_HOLD SHALL wait only for release, the repeat timer SHALL be omitted, and each press SHALL give exactly one step.

Verification (DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-026 Reset then idle -> char_out=0x41, step_pulse never asserted.
REQ-027 btn_up_n low for 3 cycles then high, with glitches -> no step; held low for 10 cycles -> one step_pulse and char_out=0x42.
REQ-028 char_out=0x7E, up press -> 0x20; char_out=0x20, down press -> 0x7E.
REQ-029 With the macro defined, up held 60 cycles from 0x41 -> steps at press, +20 and +28, +36, ... giving char_out=0x47; without the macro -> char_out=0x42.
REQ-030 Both buttons pressed together -> no step; up held then down pressed -> return to S_IDLE with no further steps.
REQ-031 rst_n pulsed low during S_REPEAT -> char_out=0x41 at once, and no step while the button stays held.
